wb_mem_map_n: RTL and testbench

- Parametrised Wishbone address decoder and response multiplexer between the CPU master and NSLV slaves (SRAM/flash controller, VDU, and future peripherals).
- Replaces the fixed two-way memory/VDU split with a table-driven, registered, one-outstanding-transaction router.
- Adds unmapped-address handling and a slave timeout, both of which return open-bus data.

---
 rtl/wb_map_pkg.sv | 27 ++
 rtl/wb_addr_dec.sv | 29 ++
 rtl/wb_mem_map_n.sv | 154 +++++++++++++++
 tb/tb_wb_mem_map_n.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_map_pkg.sv
// Shared definitions for the Wishbone memory-map router: FSM encoding,
// the open-bus read value and a width helper.
package wb_map_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Returned on unmapped reads and timeouts; sliced to the bus width at use.
    localparam logic [63:0] OPEN_BUS = '1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_addr_dec.sv
// Table-driven address decoder: priority encoder over base/mask pairs,
// lowest slot index wins.
module wb_addr_dec
    import wb_map_pkg::*;
#(
    parameter int unsigned NSLV   = 2,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned SEL_W  = (NSLV > 1) ? clog2(NSLV) : 1
) (
    input  logic [ADDR_W-1:0]      adr,
    input  logic [NSLV*ADDR_W-1:0] base,
    input  logic [NSLV*ADDR_W-1:0] mask,
    output logic                   hit_any,
    output logic [SEL_W-1:0]       sel
);

    // Walk from the highest slot down so the lowest matching index is left.
    always_comb begin
        hit_any = 1'b0;
        sel     = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if ((adr & mask[i*ADDR_W +: ADDR_W]) == base[i*ADDR_W +: ADDR_W]) begin
                hit_any = 1'b1;
                sel     = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mem_map_n.sv
// Wishbone address decoder and response mux for NSLV slaves; one transaction
// outstanding, with open-bus error responses for unmapped addresses and timeouts.
module wb_mem_map_n
    import wb_map_pkg::*;
#(
    parameter int unsigned NSLV   = 2,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16,
    // Slot 0 is the VDU window, slot 1 the catch-all memory behind it.
    parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {20'h00000, 20'hB8000},
    parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {20'h00000, 20'hFE000},
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADDR_W-1:0]      adr_i,
    input  logic [DATA_W-1:0]      dat_i,
    output logic [DATA_W-1:0]      dat_o,
    input  logic                   we_i,
    input  logic                   stb_i,
    input  logic                   byte_i,
    output logic                   ack_o,
    output logic                   err_o,
    output logic [NSLV-1:0]        s_stb_o,
    output logic [ADDR_W-1:0]      s_adr_o,
    output logic [DATA_W-1:0]      s_dat_o,
    output logic                   s_we_o,
    output logic                   s_byte_o,
    input  logic [NSLV*DATA_W-1:0] s_dat_i,
    input  logic [NSLV-1:0]        s_ack_i
);

    localparam int unsigned SEL_W = (NSLV > 1) ? clog2(NSLV) : 1;
    localparam int unsigned CNT_W = clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_any;
    logic [SEL_W-1:0]   dec_sel;

    logic               ack_d, err_d, s_we_d, s_byte_d;
    logic [DATA_W-1:0]  dat_d, s_dat_d;
    logic [ADDR_W-1:0]  s_adr_d;
    logic [NSLV-1:0]    s_stb_d;

    wb_addr_dec #(
        .NSLV   (NSLV),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_dec (
        .adr     (adr_i),
        .base    (SLV_BASE),
        .mask    (SLV_MASK),
        .hit_any (hit_any),
        .sel     (dec_sel)
    );

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_o;
        s_stb_d  = s_stb_o;
        s_adr_d  = s_adr_o;
        s_dat_d  = s_dat_o;
        s_we_d   = s_we_o;
        s_byte_d = s_byte_o;

        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    if (hit_any) begin
                        s_adr_d  = adr_i;
                        s_dat_d  = dat_i;
                        s_we_d   = we_i;
                        s_byte_d = byte_i;
                        sel_d    = dec_sel;
                        s_stb_d  = NSLV'(1) << dec_sel;
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            // Slave ack beats both a master abort and the timeout.
            BUSY: begin
                if (s_ack_i[sel_q]) begin
                    dat_d   = s_dat_i[sel_q*DATA_W +: DATA_W];
                    ack_d   = 1'b1;
                    s_stb_d = '0;
                    state_d = DONE;
                end else if (!stb_i) begin
                    s_stb_d = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    s_stb_d = '0;
                    dat_d   = OPEN_BUS[DATA_W-1:0];
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                dat_d   = OPEN_BUS[DATA_W-1:0];
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = DONE;
            end
            // Master still holds stb while it samples ack, so do not decode here.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            dat_o    <= '0;
            s_stb_o  <= '0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
            s_we_o   <= 1'b0;
            s_byte_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            ack_o    <= ack_d;
            err_o    <= err_d;
            dat_o    <= dat_d;
            s_stb_o  <= s_stb_d;
            s_adr_o  <= s_adr_d;
            s_dat_o  <= s_dat_d;
            s_we_o   <= s_we_d;
            s_byte_o <= s_byte_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_map_n.sv
// Bench for wb_mem_map_n: three slots (VDU window, overlapping I/O page,
// low-memory region) with latency-programmable slaves and stray-ack noise.
module tb_wb_mem_map_n;

    localparam int NSLV    = 3;
    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 1000;

    localparam logic [NSLV*ADDR_W-1:0] BASE_F = {20'h00000, 20'hB0000, 20'hB8000};
    localparam logic [NSLV*ADDR_W-1:0] MASK_F = {20'hE0000, 20'hF0000, 20'hFE000};

    // Address map restated as plain integers for the reference model.
    int base_t[NSLV] = '{32'hB8000, 32'hB0000, 32'h00000};
    int mask_t[NSLV] = '{32'hFE000, 32'hF0000, 32'hE0000};

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic [ADDR_W-1:0]      adr_i = '0;
    logic [DATA_W-1:0]      dat_i = '0;
    logic [DATA_W-1:0]      dat_o;
    logic                   we_i = 1'b0;
    logic                   stb_i = 1'b0;
    logic                   byte_i = 1'b0;
    logic                   ack_o;
    logic                   err_o;
    logic [NSLV-1:0]        s_stb_o;
    logic [ADDR_W-1:0]      s_adr_o;
    logic [DATA_W-1:0]      s_dat_o;
    logic                   s_we_o;
    logic                   s_byte_o;
    logic [NSLV*DATA_W-1:0] s_dat_i;
    logic [NSLV-1:0]        s_ack_i;

    int n_vec = 0;
    int n_bad = 0;

    wb_mem_map_n #(
        .NSLV     (NSLV),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SLV_BASE (BASE_F),
        .SLV_MASK (MASK_F),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .we_i     (we_i),
        .stb_i    (stb_i),
        .byte_i   (byte_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .s_stb_o  (s_stb_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_we_o   (s_we_o),
        .s_byte_o (s_byte_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i)
    );

    always #5 clk = ~clk;

    // Slaves: ack combinationally once strobed for cur_lat cycles; random
    // stray acks on every slot that is not currently strobed.
    int              cur_lat = NEVER;
    logic [15:0]     sdat = '0;
    logic            noise_en = 1'b0;
    logic [NSLV-1:0] noise = '0;
    int              wcnt[NSLV] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < NSLV; i++) wcnt[i] <= s_stb_o[i] ? wcnt[i] + 1 : 0;
        noise <= noise_en ? NSLV'($urandom) : '0;
    end

    always_comb begin
        s_ack_i = '0;
        for (int i = 0; i < NSLV; i++)
            s_ack_i[i] = s_stb_o[i] ? (wcnt[i] >= cur_lat) : noise[i];
    end

    assign s_dat_i = {sdat ^ 16'h2222, sdat ^ 16'h1111, sdat};

    typedef struct {
        logic [19:0] adr;
        logic        we;
        logic [15:0] dat;
        logic        byt;
        int          lat;
        int          abort_at;
        logic [15:0] sdat;
    } txn_t;

    typedef struct {
        int stb_val;
        int stb_cyc;
        int ack_cyc;
        int ack_cnt;
        int err;
        int dat;
        int field_bad;
    } res_t;

    typedef struct {
        txn_t t;
        res_t e;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [19:0] adr, input logic we, input logic [15:0] dat,
                                input logic byt, input int lat, input int abort_at,
                                input logic [15:0] sd, input int stb_val, input int stb_cyc,
                                input int ack_cyc, input int ack_cnt, input int err, input int edat);
        vec_t v;
        v.t.adr = adr; v.t.we = we; v.t.dat = dat; v.t.byt = byt;
        v.t.lat = lat; v.t.abort_at = abort_at; v.t.sdat = sd;
        v.e.stb_val = stb_val; v.e.stb_cyc = stb_cyc; v.e.ack_cyc = ack_cyc;
        v.e.ack_cnt = ack_cnt; v.e.err = err; v.e.dat = edat; v.e.field_bad = 0;
        return v;
    endfunction

    // Reference model: decode by table, then the earliest of ack, abort and
    // timeout (measured in clock edges after stb is sampled) decides the outcome.
    function automatic res_t model(input txn_t t);
        res_t r;
        int sel, t_ack, t_ab, t_to;
        sel = -1;
        for (int i = NSLV - 1; i >= 0; i--)
            if ((int'(t.adr) & mask_t[i]) == base_t[i]) sel = i;
        r.field_bad = 0;
        if (sel < 0) begin
            r.stb_val = 0; r.stb_cyc = 0; r.ack_cyc = 1; r.ack_cnt = 1;
            r.err = 1; r.dat = 32'hFFFF;
            return r;
        end
        r.stb_val = 1 << sel;
        t_ack = (t.lat < TIMEOUT) ? t.lat + 1 : NEVER;
        t_ab  = (t.abort_at >= 0) ? t.abort_at + 1 : NEVER;
        t_to  = TIMEOUT;
        if (t_ack <= t_ab && t_ack <= t_to) begin
            r.stb_cyc = t_ack; r.ack_cyc = t_ack; r.ack_cnt = 1; r.err = 0;
            r.dat = int'(t.sdat) ^ (32'h1111 * sel);
        end else if (t_ab <= t_to) begin
            r.stb_cyc = t_ab; r.ack_cyc = -1; r.ack_cnt = 0; r.err = 0; r.dat = 0;
        end else begin
            r.stb_cyc = t_to; r.ack_cyc = t_to; r.ack_cnt = 1; r.err = 1; r.dat = 32'hFFFF;
        end
        return r;
    endfunction

    // Drive one request and observe it cycle by cycle; cycle c is the state
    // after the c-th clock edge following stb being presented.
    task automatic run_txn(input txn_t t, output res_t o);
        int stop_at;
        o.stb_val = 0; o.stb_cyc = 0; o.ack_cyc = -1; o.ack_cnt = 0;
        o.err = 0; o.dat = 0; o.field_bad = 0;
        @(posedge clk); #1;
        cur_lat = t.lat; sdat = t.sdat;
        adr_i = t.adr; dat_i = t.dat; we_i = t.we; byte_i = t.byt; stb_i = 1'b1;
        stop_at = TIMEOUT + 12;
        for (int c = 0; c <= stop_at; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                adr_i = 20'($urandom); dat_i = 16'($urandom); we_i = ~we_i; byte_i = ~byte_i;
            end
            if (o.ack_cyc >= 0 && c == o.ack_cyc + 1) stb_i = 1'b0;
            if (t.abort_at >= 0 && c == t.abort_at) stb_i = 1'b0;
            @(negedge clk);
            if (s_stb_o != '0) begin
                if (o.stb_cyc == 0) o.stb_val = int'(s_stb_o);
                else if (int'(s_stb_o) != o.stb_val) o.field_bad = 1;
                o.stb_cyc++;
                if (s_adr_o != t.adr || s_dat_o != t.dat || s_we_o != t.we || s_byte_o != t.byt)
                    o.field_bad = 1;
            end
            if (ack_o) begin
                o.ack_cnt++;
                if (o.ack_cyc < 0) begin
                    o.ack_cyc = c; o.err = int'(err_o); o.dat = int'(dat_o);
                    stop_at = c + 3;
                end
            end else if (err_o) begin
                o.field_bad = 1;
            end
        end
        stb_i = 1'b0;
    endtask

    task automatic compare(input string nm, input res_t o, input res_t e);
        check({nm, " s_stb"}, o.stb_val, e.stb_val);
        check({nm, " stb_cycles"}, o.stb_cyc, e.stb_cyc);
        check({nm, " ack_cycle"}, o.ack_cyc, e.ack_cyc);
        check({nm, " ack_pulses"}, o.ack_cnt, e.ack_cnt);
        check({nm, " held_fields"}, o.field_bad, e.field_bad);
        if (e.ack_cnt > 0) begin
            check({nm, " err"}, o.err, e.err);
            check({nm, " dat_o"}, o.dat, e.dat);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[10];
        res_t o, e;
        txn_t t;
        logic [5:0] ack_pat, stb_pat;
        int b2b_dat;

        vecs[0] = mk(20'hB8010, 0, 16'h0000, 0, 0,     -1, 16'h0741, 1, 1, 1,  1, 0, 32'h0741);
        vecs[1] = mk(20'h01234, 1, 16'hBEEF, 1, 5,     -1, 16'h1000, 4, 6, 6,  1, 0, 32'h3222);
        vecs[2] = mk(20'h40000, 0, 16'h0000, 0, 0,     -1, 16'h0000, 0, 0, 1,  1, 1, 32'hFFFF);
        vecs[3] = mk(20'hB4000, 0, 16'h0000, 0, NEVER, -1, 16'h0000, 2, 8, 8,  1, 1, 32'hFFFF);
        vecs[4] = mk(20'hB4000, 0, 16'h0000, 0, 7,     -1, 16'h5A5A, 2, 8, 8,  1, 0, 32'h4B4B);
        vecs[5] = mk(20'h1FFFF, 0, 16'h0000, 0, 2,     -1, 16'h00F0, 4, 3, 3,  1, 0, 32'h22D2);
        vecs[6] = mk(20'h20000, 1, 16'h1234, 0, 0,     -1, 16'h0000, 0, 0, 1,  1, 1, 32'hFFFF);
        vecs[7] = mk(20'hB9FFF, 1, 16'h00AA, 0, 1,     -1, 16'hCAFE, 1, 2, 2,  1, 0, 32'hCAFE);
        vecs[8] = mk(20'hBA000, 0, 16'h0000, 0, 5,      2, 16'h0000, 2, 3, -1, 0, 0, 0);
        vecs[9] = mk(20'hB8000, 1, 16'h4321, 1, 8,     -1, 16'h7777, 1, 8, 8,  1, 1, 32'hFFFF);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset ctrl", int'({ack_o, err_o, s_stb_o, s_we_o, s_byte_o}), 0);
        check("reset dat_o", int'(dat_o), 0);
        check("reset s_adr_o", int'(s_adr_o), 0);
        check("reset s_dat_o", int'(s_dat_o), 0);
        rst_i = 1'b0;
        noise_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].t, o);
            compare($sformatf("vec%0d", i), o, vecs[i].e);
        end

        // Reset in the middle of a BUSY transaction clears outputs at once.
        @(posedge clk); #1;
        cur_lat = NEVER; adr_i = 20'hB4000; we_i = 1'b1; dat_i = 16'h5555; byte_i = 1'b1; stb_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst busy s_stb", int'(s_stb_o), 2);
        #2 rst_i = 1'b1;
        #1;
        check("midrst ctrl", int'({ack_o, err_o, s_stb_o, s_we_o, s_byte_o}), 0);
        check("midrst dat", int'({dat_o, s_dat_o}), 0);
        check("midrst s_adr", int'(s_adr_o), 0);
        stb_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        t = vecs[0].t;
        run_txn(t, o);
        compare("post_rst", o, model(t));

        // Back-to-back with stb held: the DONE cycle must not start a new decode.
        @(posedge clk); #1;
        cur_lat = 0; sdat = 16'h1357; adr_i = 20'hB8010; we_i = 1'b0; stb_i = 1'b1;
        ack_pat = '0; stb_pat = '0; b2b_dat = -1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            ack_pat[c] = ack_o;
            stb_pat[c] = (s_stb_o == 3'b001);
            if (ack_o && b2b_dat < 0) b2b_dat = int'(dat_o);
        end
        stb_i = 1'b0;
        check("b2b ack pattern", int'(ack_pat), 6'b010010);
        check("b2b stb pattern", int'(stb_pat), 6'b001001);
        check("b2b dat_o", b2b_dat, 32'h1357);

        // Random transactions against the reference model.
        for (int k = 0; k < 80; k++) begin
            case ($urandom % 5)
                0: t.adr = 20'hB8000 | 20'($urandom & 32'h1FFF);
                1: t.adr = 20'hB0000 | 20'($urandom & 32'hFFFF);
                2: t.adr = 20'($urandom & 32'h1FFFF);
                default: t.adr = 20'($urandom);
            endcase
            t.we = 1'($urandom); t.dat = 16'($urandom); t.byt = 1'($urandom);
            t.sdat = 16'($urandom); t.abort_at = -1;
            case ($urandom % 10)
                0, 1, 2, 3, 4, 5: t.lat = int'($urandom_range(0, TIMEOUT - 1));
                6, 7: t.lat = int'($urandom_range(TIMEOUT, TIMEOUT + 3));
                default: begin
                    t.abort_at = int'($urandom_range(0, TIMEOUT - 2));
                    t.lat = t.abort_at + 1 + int'($urandom_range(0, 4));
                end
            endcase
            run_txn(t, o);
            compare($sformatf("rnd%0d adr=%05h", k, t.adr), o, model(t));
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
